// File: rtl/pic_command_sequencer_if.sv
// CPU write bus from Read_Write_Logic into the 8259 command sequencer.
interface pic_command_sequencer_if;
  logic       write_enable;
  logic       a0;
  logic [7:0] data_in;

  modport master (output write_enable, output a0, output data_in);
  modport slave  (input  write_enable, input  a0, input  data_in);
endinterface

// File: rtl/pic_command_sequencer.sv
// 8259 ICW/OCW command sequencer: walks ICW1..ICW4, then decodes OCW1-3 into
// the registered configuration consumed by the rest of the PIC.
module pic_command_sequencer #(
  parameter logic [7:0] RESET_MASK = 8'hFF,
  parameter logic [7:0] INIT_MASK  = 8'h00
) (
  input  logic                          clk,
  input  logic                          reset,
  pic_command_sequencer_if.slave        i_cpu,
  output logic                          o_init_done,
  output logic                          o_ltim,
  output logic                          o_sngl,
  output logic [4:0]                    o_vector_base,
  output logic [7:0]                    o_slave_reg,
  output logic                          o_aeoi,
  output logic [7:0]                    o_irq_mask,
  output logic                          o_rotate_mode,
  output logic                          o_eoi_pulse,
  output logic                          o_eoi_specific,
  output logic [2:0]                    o_eoi_level,
  output logic [1:0]                    o_reading_status
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] S_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] S_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] S_READY     = 3'd4;

  localparam logic [1:0] RS_IRR = 2'b01;
  localparam logic [1:0] RS_ISR = 2'b10;

  logic [2:0] r_state, w_state_nxt;
  logic       r_we_d;
  logic       r_ic4, w_ic4_nxt;
  logic       r_init_done, w_init_done_nxt;
  logic       r_ltim, w_ltim_nxt;
  logic       r_sngl, w_sngl_nxt;
  logic [4:0] r_vector_base, w_vector_base_nxt;
  logic [7:0] r_slave_reg, w_slave_reg_nxt;
  logic       r_aeoi, w_aeoi_nxt;
  logic [7:0] r_irq_mask, w_irq_mask_nxt;
  logic       r_rotate_mode, w_rotate_mode_nxt;
  logic       r_eoi_pulse, w_eoi_pulse_nxt;
  logic       r_eoi_specific, w_eoi_specific_nxt;
  logic [2:0] r_eoi_level, w_eoi_level_nxt;
  logic [1:0] r_reading_status, w_reading_status_nxt;

  logic       w_accept;
  logic [7:0] w_d;

  // A write counts once per rising edge of the level strobe.
  assign w_accept = i_cpu.write_enable & ~r_we_d;
  assign w_d      = i_cpu.data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_we_d           <= 1'b0;
      r_ic4            <= 1'b0;
      r_init_done      <= 1'b0;
      r_ltim           <= 1'b0;
      r_sngl           <= 1'b1;
      r_vector_base    <= 5'd0;
      r_slave_reg      <= 8'd0;
      r_aeoi           <= 1'b0;
      r_irq_mask       <= RESET_MASK;
      r_rotate_mode    <= 1'b0;
      r_eoi_pulse      <= 1'b0;
      r_eoi_specific   <= 1'b0;
      r_eoi_level      <= 3'd0;
      r_reading_status <= RS_IRR;
    end else begin
      r_state          <= w_state_nxt;
      r_we_d           <= i_cpu.write_enable;
      r_ic4            <= w_ic4_nxt;
      r_init_done      <= w_init_done_nxt;
      r_ltim           <= w_ltim_nxt;
      r_sngl           <= w_sngl_nxt;
      r_vector_base    <= w_vector_base_nxt;
      r_slave_reg      <= w_slave_reg_nxt;
      r_aeoi           <= w_aeoi_nxt;
      r_irq_mask       <= w_irq_mask_nxt;
      r_rotate_mode    <= w_rotate_mode_nxt;
      r_eoi_pulse      <= w_eoi_pulse_nxt;
      r_eoi_specific   <= w_eoi_specific_nxt;
      r_eoi_level      <= w_eoi_level_nxt;
      r_reading_status <= w_reading_status_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_ic4_nxt            = r_ic4;
    w_init_done_nxt      = r_init_done;
    w_ltim_nxt           = r_ltim;
    w_sngl_nxt           = r_sngl;
    w_vector_base_nxt    = r_vector_base;
    w_slave_reg_nxt      = r_slave_reg;
    w_aeoi_nxt           = r_aeoi;
    w_irq_mask_nxt       = r_irq_mask;
    w_rotate_mode_nxt    = r_rotate_mode;
    w_eoi_pulse_nxt      = 1'b0;
    w_eoi_specific_nxt   = r_eoi_specific;
    w_eoi_level_nxt      = r_eoi_level;
    w_reading_status_nxt = r_reading_status;

    if (w_accept) begin
      // ICW1 restarts initialisation from any state.
      if (!i_cpu.a0 && w_d[4]) begin
        w_ltim_nxt           = w_d[3];
        w_sngl_nxt           = w_d[1];
        w_ic4_nxt            = w_d[0];
        w_irq_mask_nxt       = INIT_MASK;
        w_rotate_mode_nxt    = 1'b0;
        w_aeoi_nxt           = 1'b0;
        w_slave_reg_nxt      = 8'd0;
        w_reading_status_nxt = RS_IRR;
        w_init_done_nxt      = 1'b0;
        w_state_nxt          = S_WAIT_ICW2;
      end else begin
        case (r_state)
          S_WAIT_ICW2: if (i_cpu.a0) begin
            w_vector_base_nxt = w_d[7:3];
            if (!r_sngl) begin
              w_state_nxt = S_WAIT_ICW3;
            end else if (r_ic4) begin
              w_state_nxt = S_WAIT_ICW4;
            end else begin
              w_state_nxt     = S_READY;
              w_init_done_nxt = 1'b1;
            end
          end
          S_WAIT_ICW3: if (i_cpu.a0) begin
            w_slave_reg_nxt = w_d;
            if (r_ic4) begin
              w_state_nxt = S_WAIT_ICW4;
            end else begin
              w_state_nxt     = S_READY;
              w_init_done_nxt = 1'b1;
            end
          end
          S_WAIT_ICW4: if (i_cpu.a0) begin
            w_aeoi_nxt      = w_d[1];
            w_state_nxt     = S_READY;
            w_init_done_nxt = 1'b1;
          end
          S_READY: begin
            if (i_cpu.a0) begin
              w_irq_mask_nxt = w_d;
            end else if (!w_d[3]) begin
              // OCW2: D5 = EOI, D6 = specific, D7 = rotate (with EOI, or alone as 100).
              if (w_d[5]) begin
                w_eoi_pulse_nxt    = 1'b1;
                w_eoi_specific_nxt = w_d[6];
                if (w_d[6]) w_eoi_level_nxt = w_d[2:0];
              end
              if (w_d[7] && (w_d[5] || !w_d[6])) w_rotate_mode_nxt = 1'b1;
              if (w_d[7:5] == 3'b000) w_rotate_mode_nxt = 1'b0;
            end else if (w_d[1]) begin
              w_reading_status_nxt = w_d[0] ? RS_ISR : RS_IRR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_init_done      = r_init_done;
  assign o_ltim           = r_ltim;
  assign o_sngl           = r_sngl;
  assign o_vector_base    = r_vector_base;
  assign o_slave_reg      = r_slave_reg;
  assign o_aeoi           = r_aeoi;
  assign o_irq_mask       = r_irq_mask;
  assign o_rotate_mode    = r_rotate_mode;
  assign o_eoi_pulse      = r_eoi_pulse;
  assign o_eoi_specific   = r_eoi_specific;
  assign o_eoi_level      = r_eoi_level;
  assign o_reading_status = r_reading_status;

endmodule
